// File: rtl/image_buffer_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : image_buffer_writer_if
//  Description : Stroke request handshake between the drawing front end and
//                the image buffer writer (valid/ready plus stroke payload).
//  Revision    : 1.0 - initial release
// ============================================================================
interface image_buffer_writer_if;
  logic       paint_valid;
  logic       paint_ready;
  logic [4:0] paint_x;
  logic [4:0] paint_y;
  logic       paint_erase;

  // Front end side: issues strokes
  modport master (
    output paint_valid,
    output paint_x,
    output paint_y,
    output paint_erase,
    input  paint_ready
  );

  // Writer side: accepts strokes
  modport slave (
    input  paint_valid,
    input  paint_x,
    input  paint_y,
    input  paint_erase,
    output paint_ready
  );
endinterface
`default_nettype wire

// File: rtl/image_buffer_writer.sv
`default_nettype none
// ============================================================================
//  Module      : image_buffer_writer
//  Description : Owns the GRID x GRID Q16.16 image store. Applies paint/erase
//                strokes (optional plus-shaped brush) by read-modify-write,
//                zeroes the store on reset release or on request, keeps a
//                count of nonzero pixels and serves a 1-cycle read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module image_buffer_writer #(
  parameter int          GRID       = 28,
  parameter logic [31:0] PIXEL_ON   = 32'h0001_0000,
  parameter logic [31:0] PIXEL_HALF = 32'h0000_8000,
  parameter bit          BRUSH      = 1'b1
) (
  input  wire                  clk,
  input  wire                  resetn,
  image_buffer_writer_if.slave paint,
  input  wire                  clear,
  output logic                 busy,
  output logic                 done,
  output logic [9:0]           pixel_count,
  input  wire  [15:0]          read_addr,
  output logic [31:0]          data_out
);

  localparam int         DEPTH     = GRID * GRID;
  localparam logic [9:0] DEPTH_W   = 10'(DEPTH);
  localparam logic [9:0] LAST_ADDR = 10'(DEPTH - 1);
  localparam logic [9:0] GRID_W    = 10'(GRID);
  localparam logic [5:0] GRID6     = 6'(GRID);
  // Cell 0 is the centre; cells 1..4 are up, down, left, right
  localparam logic [2:0] LAST_CELL = BRUSH ? 3'd4 : 3'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_P_RD  = 2'd2,
    S_P_WR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  addr_q, addr_d;          // sweep address in CLEAR, cell address in P_WR
  logic [2:0]  cell_q, cell_d;
  logic [4:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic        erase_q, erase_d;
  logic        clear_pending_q, clear_pending_d;
  logic        done_q, done_d;
  logic [9:0]  count_q, count_d;
  logic [31:0] data_out_q, data_out_d;

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] rd_word_q;               // word read in P_RD, consumed in P_WR
  logic        mem_we;
  logic [9:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] new_word;

  logic [5:0]  cx, cy;
  logic        cell_under;
  logic        cell_off;
  logic [9:0]  cell_addr;
  logic [9:0]  rd_idx;

  assign paint.paint_ready = (state_q == S_IDLE) && !clear && !clear_pending_q;
  assign busy              = (state_q != S_IDLE);
  assign done              = done_q;
  assign pixel_count       = count_q;
  assign data_out          = data_out_q;

  // Coordinates and address of the cell currently being processed
  always_comb begin
    cx         = {1'b0, x_q};
    cy         = {1'b0, y_q};
    cell_under = 1'b0;
    case (cell_q)
      3'd1: begin
        cell_under = (y_q == 5'd0);
        cy         = {1'b0, y_q} - 6'd1;
      end
      3'd2: cy = {1'b0, y_q} + 6'd1;
      3'd3: begin
        cell_under = (x_q == 5'd0);
        cx         = {1'b0, x_q} - 6'd1;
      end
      3'd4: cx = {1'b0, x_q} + 6'd1;
      default: ;
    endcase
    cell_off  = cell_under || (cx >= GRID6) || (cy >= GRID6);
    cell_addr = 10'(cy) * GRID_W + 10'(cx);
    rd_idx    = (cell_addr < DEPTH_W) ? cell_addr : 10'd0;
  end

  // Network read port: out-of-range addresses read as zero
  always_comb begin
    data_out_d = '0;
    if (read_addr < 16'(DEPTH)) begin
      data_out_d = mem[read_addr[9:0]];
    end
  end

  // Pixel store write port and internal read for read-modify-write
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_word_q <= mem[rd_idx];
  end

  // Control state, stroke latches, pixel count and registered read data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= S_CLEAR;
      addr_q          <= '0;
      cell_q          <= '0;
      x_q             <= '0;
      y_q             <= '0;
      erase_q         <= 1'b0;
      clear_pending_q <= 1'b0;
      done_q          <= 1'b0;
      count_q         <= '0;
      data_out_q      <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      cell_q          <= cell_d;
      x_q             <= x_d;
      y_q             <= y_d;
      erase_q         <= erase_d;
      clear_pending_q <= clear_pending_d;
      done_q          <= done_d;
      count_q         <= count_d;
      data_out_q      <= data_out_d;
    end
  end

  // Next-state logic: clear sweep, per-cell read then write, count tracking
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cell_d          = cell_q;
    x_d             = x_q;
    y_d             = y_q;
    erase_d         = erase_q;
    clear_pending_d = clear_pending_q;
    done_d          = 1'b0;
    count_d         = count_q;
    mem_we          = 1'b0;
    mem_waddr       = addr_q;
    mem_wdata       = '0;
    new_word        = '0;

    case (state_q)
      S_IDLE: begin
        if (clear || clear_pending_q) begin
          state_d         = S_CLEAR;
          addr_d          = '0;
          clear_pending_d = 1'b0;
        end else if (paint.paint_valid) begin
          x_d     = paint.paint_x;
          y_d     = paint.paint_y;
          erase_d = paint.paint_erase;
          cell_d  = '0;
          state_d = S_P_RD;
        end
      end

      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = addr_q;
        mem_wdata = '0;
        if (addr_q == LAST_ADDR) begin
          count_d = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          addr_d = addr_q + 10'd1;
        end
      end

      S_P_RD: begin
        if (clear) begin
          clear_pending_d = 1'b1;
        end
        if (cell_off) begin
          // Off-grid cells cost a single cycle and touch nothing
          if (cell_q == LAST_CELL) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cell_d = cell_q + 3'd1;
          end
        end else begin
          addr_d  = cell_addr;
          state_d = S_P_WR;
        end
      end

      S_P_WR: begin
        if (clear) begin
          clear_pending_d = 1'b1;
        end
        // Neighbours only light dark pixels; they never lower a lit one
        if (erase_q) begin
          new_word = '0;
        end else if (cell_q == 3'd0) begin
          new_word = PIXEL_ON;
        end else if (rd_word_q == 32'd0) begin
          new_word = PIXEL_HALF;
        end else begin
          new_word = rd_word_q;
        end
        mem_we    = 1'b1;
        mem_waddr = addr_q;
        mem_wdata = new_word;
        if ((rd_word_q == 32'd0) && (new_word != 32'd0) && (count_q != DEPTH_W)) begin
          count_d = count_q + 10'd1;
        end else if ((rd_word_q != 32'd0) && (new_word == 32'd0) && (count_q != 10'd0)) begin
          count_d = count_q - 10'd1;
        end
        if (cell_q == LAST_CELL) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cell_d  = cell_q + 3'd1;
          state_d = S_P_RD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_image_buffer_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_buffer_writer
//  Description : Self-checking bench for image_buffer_writer. A pixel-array
//                model applies each stroke cell by cell and predicts contents,
//                lit-pixel count and stroke duration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_image_buffer_writer;

  localparam int          GRID  = 28;
  localparam int          DEPTH = GRID * GRID;
  localparam bit          BRUSH = 1'b1;
  localparam logic [31:0] ON    = 32'h0001_0000;
  localparam logic [31:0] HALF  = 32'h0000_8000;

  logic        clk;
  logic        resetn;
  logic        clear;
  logic [15:0] read_addr;
  logic        busy;
  logic        done;
  logic [9:0]  pixel_count;
  logic [31:0] data_out;

  image_buffer_writer_if pif ();

  image_buffer_writer #(
    .GRID       (GRID),
    .PIXEL_ON   (ON),
    .PIXEL_HALF (HALF),
    .BRUSH      (BRUSH)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .paint       (pif),
    .clear       (clear),
    .busy        (busy),
    .done        (done),
    .pixel_count (pixel_count),
    .read_addr   (read_addr),
    .data_out    (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model_mem [DEPTH];

  // ---------------- reference model ----------------
  function automatic void model_clear();
    foreach (model_mem[i]) model_mem[i] = 32'd0;
  endfunction

  function automatic int model_count();
    int c = 0;
    foreach (model_mem[i]) if (model_mem[i] != 32'd0) c++;
    return c;
  endfunction

  // Applies a stroke to the model and returns its expected duration in cycles
  function automatic int model_stroke(input int x, input int y, input bit er);
    int dx[5] = '{0, 0, 0, -1, 1};
    int dy[5] = '{0, -1, 1, 0, 0};
    int cyc = 0;
    int n = BRUSH ? 5 : 1;
    for (int k = 0; k < n; k++) begin
      int cx = x + dx[k];
      int cy = y + dy[k];
      if (cx < 0 || cy < 0 || cx >= GRID || cy >= GRID) begin
        cyc += 1;
      end else begin
        int a = cy * GRID + cx;
        cyc += 2;
        if (er) model_mem[a] = 32'd0;
        else if (k == 0) model_mem[a] = ON;
        else if (model_mem[a] == 32'd0) model_mem[a] = HALF;
      end
    end
    return cyc;
  endfunction

  // ---------------- stimulus tasks (called at a negedge) ----------------
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic stroke(input int x, input int y, input bit er, output int cycles);
    int w = 0;
    while (pif.paint_ready !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    pif.paint_x     = 5'(x);
    pif.paint_y     = 5'(y);
    pif.paint_erase = er;
    pif.paint_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pif.paint_valid = 1'b0;
    wait_done(cycles);
  endtask

  task automatic do_clear(output int cycles);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    wait_done(cycles);
  endtask

  task automatic read_word(input int a, output logic [31:0] d);
    read_addr = 16'(a);
    @(negedge clk);
    d = data_out;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n = 0;
    logic [31:0] d;
    int addrs[3] = '{0, 400, 783};
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b expected 1", busy); else n_pass++;
    n_checks++; if (pif.paint_ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", pif.paint_ready); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (pixel_count !== 10'd0) $display("FAIL rst_count: got %0d expected 0", pixel_count); else n_pass++;
    n_checks++; if (data_out !== 32'd0) $display("FAIL rst_data_out: got %h expected 0", data_out); else n_pass++;
    resetn = 1'b1;
    while (busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    n_checks++; if (n != DEPTH) $display("FAIL rst_busy_cycles: got %0d expected %0d", n, DEPTH); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL rst_done_pulse: got %b expected 1", done); else n_pass++;
    n_checks++; if (pif.paint_ready !== 1'b1) $display("FAIL rst_ready_after: got %b expected 1", pif.paint_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done_width: got %b expected 0", done); else n_pass++;
    model_clear();
    foreach (addrs[i]) begin
      read_word(addrs[i], d);
      n_checks++; if (d !== 32'd0) $display("FAIL rst_read[%0d]: got %h expected 0", addrs[i], d); else n_pass++;
    end
    n_checks++; if (pixel_count !== 10'd0) $display("FAIL rst_count_after: got %0d expected 0", pixel_count); else n_pass++;
  endtask

  task automatic test_paint_centre();
    int cyc, exp_cyc;
    logic [31:0] d;
    int addrs[5] = '{145, 117, 173, 144, 146};
    exp_cyc = model_stroke(5, 5, 1'b0);
    stroke(5, 5, 1'b0, cyc);
    n_checks++; if (cyc != exp_cyc) $display("FAIL paint55_cycles: got %0d expected %0d", cyc, exp_cyc); else n_pass++;
    foreach (addrs[i]) begin
      read_word(addrs[i], d);
      n_checks++; if (d !== model_mem[addrs[i]]) $display("FAIL paint55_mem[%0d]: got %h expected %h", addrs[i], d, model_mem[addrs[i]]); else n_pass++;
    end
    n_checks++; if (pixel_count !== 10'(model_count())) $display("FAIL paint55_count: got %0d expected %0d", pixel_count, model_count()); else n_pass++;
  endtask

  task automatic test_corner();
    int cyc, exp_cyc;
    logic [31:0] d;
    int addrs[4] = '{0, 28, 1, 29};
    do_clear(cyc);
    model_clear();
    n_checks++; if (cyc != DEPTH) $display("FAIL clear_cycles: got %0d expected %0d", cyc, DEPTH); else n_pass++;
    n_checks++; if (pixel_count !== 10'd0) $display("FAIL clear_count: got %0d expected 0", pixel_count); else n_pass++;
    exp_cyc = model_stroke(0, 0, 1'b0);
    stroke(0, 0, 1'b0, cyc);
    n_checks++; if (cyc != exp_cyc) $display("FAIL corner_cycles: got %0d expected %0d", cyc, exp_cyc); else n_pass++;
    foreach (addrs[i]) begin
      read_word(addrs[i], d);
      n_checks++; if (d !== model_mem[addrs[i]]) $display("FAIL corner_mem[%0d]: got %h expected %h", addrs[i], d, model_mem[addrs[i]]); else n_pass++;
    end
    n_checks++; if (pixel_count !== 10'(model_count())) $display("FAIL corner_count: got %0d expected %0d", pixel_count, model_count()); else n_pass++;
  endtask

  task automatic test_overlap_and_erase();
    int cyc, exp_cyc;
    logic [31:0] d;
    int ov[6]  = '{145, 173, 201, 172, 174, 117};
    int er[5]  = '{145, 117, 173, 144, 146};
    do_clear(cyc);
    model_clear();
    exp_cyc = model_stroke(5, 5, 1'b0);
    stroke(5, 5, 1'b0, cyc);
    exp_cyc = model_stroke(5, 6, 1'b0);
    stroke(5, 6, 1'b0, cyc);
    n_checks++; if (cyc != exp_cyc) $display("FAIL overlap_cycles: got %0d expected %0d", cyc, exp_cyc); else n_pass++;
    foreach (ov[i]) begin
      read_word(ov[i], d);
      n_checks++; if (d !== model_mem[ov[i]]) $display("FAIL overlap_mem[%0d]: got %h expected %h", ov[i], d, model_mem[ov[i]]); else n_pass++;
    end
    n_checks++; if (pixel_count !== 10'(model_count())) $display("FAIL overlap_count: got %0d expected %0d", pixel_count, model_count()); else n_pass++;
    exp_cyc = model_stroke(5, 5, 1'b1);
    stroke(5, 5, 1'b1, cyc);
    n_checks++; if (cyc != exp_cyc) $display("FAIL erase_cycles: got %0d expected %0d", cyc, exp_cyc); else n_pass++;
    foreach (er[i]) begin
      read_word(er[i], d);
      n_checks++; if (d !== model_mem[er[i]]) $display("FAIL erase_mem[%0d]: got %h expected %h", er[i], d, model_mem[er[i]]); else n_pass++;
    end
    n_checks++; if (pixel_count !== 10'(model_count())) $display("FAIL erase_count: got %0d expected %0d", pixel_count, model_count()); else n_pass++;
  endtask

  task automatic test_offgrid_and_clear();
    int cyc, exp_cyc, n;
    logic [31:0] d;
    // Fully off-grid stroke
    exp_cyc = model_stroke(30, 3, 1'b0);
    stroke(30, 3, 1'b0, cyc);
    n_checks++; if (cyc != exp_cyc) $display("FAIL offgrid_cycles: got %0d expected %0d", cyc, exp_cyc); else n_pass++;
    n_checks++; if (pixel_count !== 10'(model_count())) $display("FAIL offgrid_count: got %0d expected %0d", pixel_count, model_count()); else n_pass++;
    // Clear pulsed in the middle of a stroke
    exp_cyc = model_stroke(10, 10, 1'b0);
    pif.paint_x = 5'd10; pif.paint_y = 5'd10; pif.paint_erase = 1'b0; pif.paint_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pif.paint_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (n != exp_cyc) $display("FAIL midclear_stroke_cycles: got %0d expected %0d", n, exp_cyc); else n_pass++;
    n_checks++; if (pif.paint_ready !== 1'b0) $display("FAIL midclear_ready: got %b expected 0", pif.paint_ready); else n_pass++;
    @(negedge clk);
    n = 1;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    model_clear();
    n_checks++; if (n != DEPTH + 1) $display("FAIL midclear_clear_cycles: got %0d expected %0d", n, DEPTH + 1); else n_pass++;
    n_checks++; if (pixel_count !== 10'd0) $display("FAIL midclear_count: got %0d expected 0", pixel_count); else n_pass++;
    read_word(290, d);
    n_checks++; if (d !== 32'd0) $display("FAIL midclear_mem[290]: got %h expected 0", d); else n_pass++;
    // Clear and stroke in the same IDLE cycle: clear wins, stroke waits
    pif.paint_x = 5'd7; pif.paint_y = 5'd7; pif.paint_erase = 1'b0; pif.paint_valid = 1'b1;
    clear = 1'b1;
    #1;
    n_checks++; if (pif.paint_ready !== 1'b0) $display("FAIL collide_ready: got %b expected 0", pif.paint_ready); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL collide_busy: got %b expected 1", busy); else n_pass++;
    wait_done(cyc);
    n_checks++; if (cyc != DEPTH) $display("FAIL collide_clear_cycles: got %0d expected %0d", cyc, DEPTH); else n_pass++;
    exp_cyc = model_stroke(7, 7, 1'b0);
    @(posedge clk);
    @(negedge clk);
    pif.paint_valid = 1'b0;
    wait_done(cyc);
    n_checks++; if (cyc != exp_cyc) $display("FAIL collide_stroke_cycles: got %0d expected %0d", cyc, exp_cyc); else n_pass++;
    read_word(7 * GRID + 7, d);
    n_checks++; if (d !== model_mem[7 * GRID + 7]) $display("FAIL collide_mem: got %h expected %h", d, model_mem[7 * GRID + 7]); else n_pass++;
    n_checks++; if (pixel_count !== 10'(model_count())) $display("FAIL collide_count: got %0d expected %0d", pixel_count, model_count()); else n_pass++;
    // Out-of-range read addresses
    read_word(900, d);
    n_checks++; if (d !== 32'd0) $display("FAIL read900: got %h expected 0", d); else n_pass++;
    read_word(DEPTH, d);
    n_checks++; if (d !== 32'd0) $display("FAIL read784: got %h expected 0", d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc, exp_cyc, x, y;
    x = $urandom_range(0, 27);
    y = $urandom_range(0, 27);
    pif.paint_x = 5'(x); pif.paint_y = 5'(y); pif.paint_erase = 1'b0; pif.paint_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_cyc = model_stroke(x, y, 1'b0);
      @(posedge clk);
      @(negedge clk);
      wait_done(cyc);
      n_checks++; if (cyc != exp_cyc) $display("FAIL b2b_cycles[%0d]: got %0d expected %0d", k, cyc, exp_cyc); else n_pass++;
      n_checks++; if (pixel_count !== 10'(model_count())) $display("FAIL b2b_count[%0d]: got %0d expected %0d", k, pixel_count, model_count()); else n_pass++;
      x = $urandom_range(0, 27);
      y = $urandom_range(0, 27);
      pif.paint_x = 5'(x);
      pif.paint_y = 5'(y);
    end
    pif.paint_valid = 1'b0;
  endtask

  task automatic test_random();
    int cyc, exp_cyc, x, y, bad;
    bit er;
    logic [31:0] d;
    for (int k = 0; k < 60; k++) begin
      x  = $urandom_range(0, 31);
      y  = $urandom_range(0, 31);
      er = ($urandom_range(0, 3) == 0);
      exp_cyc = model_stroke(x, y, er);
      stroke(x, y, er, cyc);
      n_checks++; if (cyc != exp_cyc) $display("FAIL rand_cycles[%0d] (%0d,%0d,%0b): got %0d expected %0d", k, x, y, er, cyc, exp_cyc); else n_pass++;
      n_checks++; if (pixel_count !== 10'(model_count())) $display("FAIL rand_count[%0d]: got %0d expected %0d", k, pixel_count, model_count()); else n_pass++;
    end
    bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      read_word(a, d);
      n_checks++;
      if (d !== model_mem[a]) begin
        if (bad < 10) $display("FAIL sweep_mem[%0d]: got %h expected %h", a, d, model_mem[a]);
        bad++;
      end else begin
        n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_stroke();
    int n = 0;
    logic [31:0] d;
    pif.paint_x = 5'd12; pif.paint_y = 5'd12; pif.paint_erase = 1'b0; pif.paint_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pif.paint_valid = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b1) $display("FAIL midrst_busy: got %b expected 1", busy); else n_pass++;
    n_checks++; if (pixel_count !== 10'd0) $display("FAIL midrst_count: got %0d expected 0", pixel_count); else n_pass++;
    n_checks++; if (pif.paint_ready !== 1'b0) $display("FAIL midrst_ready: got %b expected 0", pif.paint_ready); else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    while (busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    model_clear();
    n_checks++; if (n != DEPTH) $display("FAIL midrst_busy_cycles: got %0d expected %0d", n, DEPTH); else n_pass++;
    read_word(12 * GRID + 12, d);
    n_checks++; if (d !== 32'd0) $display("FAIL midrst_mem: got %h expected 0", d); else n_pass++;
  endtask

  // ---------------- sequence ----------------
  initial begin
    resetn          = 1'b1;
    clear           = 1'b0;
    read_addr       = 16'd0;
    pif.paint_valid = 1'b0;
    pif.paint_x     = 5'd0;
    pif.paint_y     = 5'd0;
    pif.paint_erase = 1'b0;
    test_reset();
    test_paint_centre();
    test_corner();
    test_overlap_and_erase();
    test_offgrid_and_clear();
    test_back_to_back();
    test_random();
    test_reset_mid_stroke();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
